// File: rtl/agp32_mem_ctrl.sv
// agp32 memory-side controller: serialises each processor command into an
// optional data access followed by an instruction fetch on one shared
// req/rvalid memory bus, with a power-up wait, per-access watchdog and
// sticky error reporting.
`timescale 1ns/1ps

module agp32_mem_ctrl #(
  parameter int INIT_WAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] pc,
  output logic        ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        mem_start_ready,
  output logic [1:0]  error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int INIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [31:0] NOP_INST = 32'd63;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DATA,
    FETCH,
    ERR
  } state_t;

  state_t            state_q;
  logic [INIT_W-1:0] initCnt_q;
  logic [INIT_W-1:0] initCnt_d;
  logic [WD_W-1:0]   watchdog_q;
  logic [WD_W-1:0]   watchdog_d;
  logic              wdExpired;
  logic              initDone;
  logic              accDone;
  logic              busErr;
  logic [2:0]        cmd_q;
  logic [31:2]       pcWord_q;

  logic              ready_q;
  logic [31:0]       instRdata_q;
  logic [31:0]       dataRdata_q;
  logic              memStartReady_q;
  logic [1:0]        error_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [31:0]       memAddr_q;
  logic [31:0]       memWdata_q;
  logic [3:0]        memWstrb_q;

  // Byte-offset bits are dropped because the bus is word addressed.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{data_addr[1:0], pc[1:0]};

  // Counter increments and terminal-count / bus-response decodes.
  always_comb begin
    initCnt_d  = initCnt_q + INIT_W'(1);
    watchdog_d = watchdog_q + WD_W'(1);
    initDone   = (initCnt_q == INIT_W'(INIT_WAIT - 1));
    wdExpired  = (watchdog_q == WD_W'(TIMEOUT - 1));
    accDone    = mem_rvalid && !mem_err;
    busErr     = mem_rvalid && mem_err;
  end

  // Main sequencer: power-up wait, command capture, data access, fetch, error lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= INIT;
      initCnt_q       <= '0;
      watchdog_q      <= '0;
      cmd_q           <= '0;
      pcWord_q        <= '0;
      ready_q         <= 1'b0;
      instRdata_q     <= NOP_INST;
      dataRdata_q     <= '0;
      memStartReady_q <= 1'b0;
      error_q         <= 2'd0;
      memReq_q        <= 1'b0;
      memWe_q         <= 1'b0;
      memAddr_q       <= '0;
      memWdata_q      <= '0;
      memWstrb_q      <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (initDone) begin
            memStartReady_q <= 1'b1;
            ready_q         <= 1'b1;
            state_q         <= IDLE;
          end else begin
            initCnt_q <= initCnt_d;
          end
        end

        IDLE: begin
          if (command != 3'd0) begin
            cmd_q      <= command;
            pcWord_q   <= pc[31:2];
            ready_q    <= 1'b0;
            watchdog_q <= '0;
            memReq_q   <= 1'b1;
            if (command == 3'd2 || command == 3'd3) begin
              state_q   <= DATA;
              memAddr_q <= {data_addr[31:2], 2'b00};
              if (command == 3'd3) begin
                memWe_q    <= 1'b1;
                memWdata_q <= data_wdata;
                memWstrb_q <= data_wstrb;
              end else begin
                memWe_q    <= 1'b0;
                memWstrb_q <= 4'b0000;
              end
            end else begin
              state_q    <= FETCH;
              memAddr_q  <= {pc[31:2], 2'b00};
              memWe_q    <= 1'b0;
              memWstrb_q <= 4'b0000;
            end
          end
        end

        DATA: begin
          if (busErr) begin
            error_q  <= 2'd2;
            memReq_q <= 1'b0;
            state_q  <= ERR;
          end else if (accDone) begin
            if (cmd_q == 3'd2) begin
              dataRdata_q <= mem_rdata;
            end
            state_q    <= FETCH;
            memAddr_q  <= {pcWord_q, 2'b00};
            memWe_q    <= 1'b0;
            memWstrb_q <= 4'b0000;
            watchdog_q <= '0;
          end else if (wdExpired) begin
            error_q  <= 2'd1;
            memReq_q <= 1'b0;
            state_q  <= ERR;
          end else begin
            watchdog_q <= watchdog_d;
          end
        end

        FETCH: begin
          if (busErr) begin
            error_q  <= 2'd2;
            memReq_q <= 1'b0;
            state_q  <= ERR;
          end else if (accDone) begin
            instRdata_q <= mem_rdata;
            memReq_q    <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end else if (wdExpired) begin
            error_q  <= 2'd1;
            memReq_q <= 1'b0;
            state_q  <= ERR;
          end else begin
            watchdog_q <= watchdog_d;
          end
        end

        ERR: begin
          ready_q  <= 1'b0;
          memReq_q <= 1'b0;
        end

        default: begin
          ready_q  <= 1'b0;
          memReq_q <= 1'b0;
          state_q  <= ERR;
        end
      endcase
    end
  end

  assign ready           = ready_q;
  assign inst_rdata      = instRdata_q;
  assign data_rdata      = dataRdata_q;
  assign mem_start_ready = memStartReady_q;
  assign error           = error_q;
  assign mem_req         = memReq_q;
  assign mem_we          = memWe_q;
  assign mem_addr        = memAddr_q;
  assign mem_wdata       = memWdata_q;
  assign mem_wstrb       = memWstrb_q;

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// Directed self-checking bench for agp32_mem_ctrl with a simple
// configurable-latency bus responder and an access log.
`timescale 1ns/1ps

module tb_agp32_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  command = 3'd0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] pc = '0;
  logic        ready;
  logic [31:0] inst_rdata;
  logic [31:0] data_rdata;
  logic        mem_start_ready;
  logic [1:0]  error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  int checks = 0;
  int failures = 0;

  // Bus responder configuration and access log
  int          busWait = 0;
  bit          busHang = 1'b0;
  bit          errEnable = 1'b0;
  logic [31:0] errAddr = '0;
  int          waitCnt = 0;
  bit          prevDone = 1'b0;
  int          logCount = 0;
  logic [31:0] logAddr  [0:15];
  logic        logWe    [0:15];
  logic [3:0]  logWstrb [0:15];
  logic [31:0] logWdata [0:15];

  agp32_mem_ctrl #(
    .INIT_WAIT(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .command(command),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .pc(pc),
    .ready(ready),
    .inst_rdata(inst_rdata),
    .data_rdata(data_rdata),
    .mem_start_ready(mem_start_ready),
    .error(error),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Bus responder: answers each access after busWait idle cycles and logs it
  always @(negedge clk) begin
    if (rst_n !== 1'b1 || mem_req !== 1'b1) begin
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      waitCnt    = 0;
      prevDone   = 1'b0;
    end else begin
      if (prevDone) waitCnt = 0;
      if (!busHang && waitCnt == busWait) begin
        mem_rvalid = 1'b1;
        mem_err    = errEnable && (mem_addr == errAddr);
        mem_rdata  = (mem_addr == 32'h200) ? 32'hDEADBEEF : {16'hC0DE, mem_addr[15:0]};
        if (logCount < 16) begin
          logAddr[logCount]  = mem_addr;
          logWe[logCount]    = mem_we;
          logWstrb[logCount] = mem_wstrb;
          logWdata[logCount] = mem_wdata;
        end
        logCount++;
        prevDone = 1'b1;
      end else begin
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        waitCnt++;
        prevDone   = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd0);
    checkOutput({tag, "_msr"}, {31'd0, mem_start_ready}, 32'd0);
    checkOutput({tag, "_error"}, {30'd0, error}, 32'd0);
    checkOutput({tag, "_memReq"}, {31'd0, mem_req}, 32'd0);
    checkOutput({tag, "_memAddr"}, mem_addr, 32'd0);
    checkOutput({tag, "_memWstrb"}, {28'd0, mem_wstrb}, 32'd0);
    checkOutput({tag, "_inst"}, inst_rdata, 32'd63);
    checkOutput({tag, "_data"}, data_rdata, 32'd0);
  endtask

  // Waits out the power-up delay after reset release, checking each cycle
  task automatic waitInit(input string tag);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_msr"}, {31'd0, mem_start_ready}, (i == 4) ? 32'd1 : 32'd0);
      checkOutput({tag, "_noReq"}, {31'd0, mem_req}, 32'd0);
    end
    checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  // Issues one command and measures how long ready stays low
  task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] dAddr,
                               input logic [31:0] wData, input logic [3:0] wStrb,
                               input logic [31:0] pcVal,
                               output int lowCycles, output int reqCycles);
    bit done;
    @(negedge clk);
    command    = cmd;
    data_addr  = dAddr;
    data_wdata = wData;
    data_wstrb = wStrb;
    pc         = pcVal;
    @(posedge clk);
    #1;
    command = 3'd0;
    lowCycles = 0;
    reqCycles = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (mem_req) reqCycles++;
      if (ready) done = 1'b1;
      else lowCycles++;
    end
    checkOutput("cmdCompletes", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int low;
    int req;
    int logStart;

    $display("[TB] agp32_mem_ctrl directed test");

    // Reset and power-up wait
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    waitInit("init");
    checkOutput("initInst", inst_rdata, 32'd63);

    // Plain fetch on a zero-wait bus
    busWait = 0;
    logStart = logCount;
    applyStimulus(3'd1, 32'h0, 32'h0, 4'h0, 32'h104, low, req);
    checkOutput("fetchLow", low, 32'd1);
    checkOutput("fetchReq", req, 32'd1);
    checkOutput("fetchCount", logCount - logStart, 32'd1);
    checkOutput("fetchAddr", logAddr[logStart], 32'h104);
    checkOutput("fetchWe", {31'd0, logWe[logStart]}, 32'd0);
    checkOutput("fetchInst", inst_rdata, 32'hC0DE0104);

    // Read plus fetch, unaligned data address
    logStart = logCount;
    applyStimulus(3'd2, 32'h203, 32'h0, 4'h0, 32'h10, low, req);
    checkOutput("readLow", low, 32'd2);
    checkOutput("readCount", logCount - logStart, 32'd2);
    checkOutput("readAddr0", logAddr[logStart], 32'h200);
    checkOutput("readWe0", {31'd0, logWe[logStart]}, 32'd0);
    checkOutput("readWstrb0", {28'd0, logWstrb[logStart]}, 32'd0);
    checkOutput("readAddr1", logAddr[logStart + 1], 32'h10);
    checkOutput("readData", data_rdata, 32'hDEADBEEF);
    checkOutput("readInst", inst_rdata, 32'hC0DE0010);

    // Write plus fetch with three wait states per access
    busWait = 3;
    logStart = logCount;
    applyStimulus(3'd3, 32'h40, 32'h12345678, 4'b0100, 32'h20, low, req);
    checkOutput("writeLow", low, 32'd8);
    checkOutput("writeReq", req, 32'd8);
    checkOutput("writeCount", logCount - logStart, 32'd2);
    checkOutput("writeAddr0", logAddr[logStart], 32'h40);
    checkOutput("writeWe0", {31'd0, logWe[logStart]}, 32'd1);
    checkOutput("writeWstrb0", {28'd0, logWstrb[logStart]}, 32'h4);
    checkOutput("writeWdata0", logWdata[logStart], 32'h12345678);
    checkOutput("writeAddr1", logAddr[logStart + 1], 32'h20);
    checkOutput("writeWe1", {31'd0, logWe[logStart + 1]}, 32'd0);
    checkOutput("writeWstrb1", {28'd0, logWstrb[logStart + 1]}, 32'd0);
    checkOutput("writeKeepsData", data_rdata, 32'hDEADBEEF);
    checkOutput("writeInst", inst_rdata, 32'hC0DE0020);

    // Interrupt-fetch and out-of-range command both fetch only
    busWait = 0;
    logStart = logCount;
    applyStimulus(3'd4, 32'h200, 32'h0, 4'hF, 32'h30, low, req);
    checkOutput("irqLow", low, 32'd1);
    checkOutput("irqCount", logCount - logStart, 32'd1);
    checkOutput("irqAddr", logAddr[logStart], 32'h30);
    checkOutput("irqKeepsData", data_rdata, 32'hDEADBEEF);
    logStart = logCount;
    applyStimulus(3'd7, 32'h200, 32'h0, 4'hF, 32'h36, low, req);
    checkOutput("cmd7Low", low, 32'd1);
    checkOutput("cmd7Addr", logAddr[logStart], 32'h34);
    checkOutput("cmd7We", {31'd0, logWe[logStart]}, 32'd0);
    checkOutput("cmd7Inst", inst_rdata, 32'hC0DE0034);

    // Watchdog timeout with a bus that never answers
    busHang = 1'b1;
    @(negedge clk);
    command = 3'd1;
    pc = 32'h50;
    @(posedge clk);
    #1;
    command = 3'd0;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk);
      #1;
      if (i == 254) begin
        checkOutput("wdBeforeError", {30'd0, error}, 32'd0);
        checkOutput("wdBeforeReq", {31'd0, mem_req}, 32'd1);
      end
    end
    checkOutput("wdError", {30'd0, error}, 32'd1);
    checkOutput("wdReqDropped", {31'd0, mem_req}, 32'd0);
    checkOutput("wdReady", {31'd0, ready}, 32'd0);
    @(negedge clk);
    command = 3'd2;
    data_addr = 32'h200;
    @(posedge clk);
    #1;
    command = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("errIgnoreReady", {31'd0, ready}, 32'd0);
    checkOutput("errIgnoreReq", {31'd0, mem_req}, 32'd0);
    checkOutput("errIgnoreError", {30'd0, error}, 32'd1);
    busHang = 1'b0;

    // Reset out of the timeout error, then a bus error on the data beat
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("rstAfterTimeout");
    @(negedge clk);
    rst_n = 1'b1;
    waitInit("reinit1");
    errEnable = 1'b1;
    errAddr = 32'h200;
    logStart = logCount;
    @(negedge clk);
    command = 3'd2;
    data_addr = 32'h201;
    pc = 32'h10;
    @(posedge clk);
    #1;
    command = 3'd0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("busErrError", {30'd0, error}, 32'd2);
    checkOutput("busErrReq", {31'd0, mem_req}, 32'd0);
    checkOutput("busErrReady", {31'd0, ready}, 32'd0);
    checkOutput("busErrNoFetch", logCount - logStart, 32'd1);
    checkOutput("busErrData", data_rdata, 32'd0);
    errEnable = 1'b0;

    // Reset pulse while locked in the error state
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("rstInErr");
    @(negedge clk);
    rst_n = 1'b1;
    waitInit("reinit2");
    logStart = logCount;
    applyStimulus(3'd1, 32'h0, 32'h0, 4'h0, 32'h104, low, req);
    checkOutput("recoverLow", low, 32'd1);
    checkOutput("recoverInst", inst_rdata, 32'hC0DE0104);
    checkOutput("recoverError", {30'd0, error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
